// File: rtl/lc3b_fetch_stage.sv
// lc3b_fetch_stage: LC-3b fetch stage with IF/ID register, stall skid and redirect drop handling.
module lc3b_fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        forward_load,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  output logic        if_id_valid,
  output logic [15:0] if_id_ir,
  output logic [15:0] if_id_pc,
  output logic [2:0]  if_id_dest,
  output logic [2:0]  if_id_sr1,
  output logic [2:0]  if_id_sr2,
  output logic        fetch_busy
);
  typedef enum logic [1:0] {FETCH, SKID, DROP} state_t;
  state_t state, state_n;
  logic [15:0] pc, pc_n, ir_n, ifpc_n, skid, skid_n, pending, pending_n;
  logic valid_n;
  logic [3:0] op;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc <= '0;
      if_id_valid <= 1'b0;
      if_id_ir <= '0;
      if_id_pc <= '0;
      skid <= '0;
      pending <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if_id_valid <= valid_n;
      if_id_ir <= ir_n;
      if_id_pc <= ifpc_n;
      skid <= skid_n;
      pending <= pending_n;
    end
  end
  // Redirect squashes IF/ID up front; the state arms below only pick the PC/state follow-up.
  always_comb begin
    state_n = state;
    pc_n = pc;
    valid_n = if_id_valid;
    ir_n = if_id_ir;
    ifpc_n = if_id_pc;
    skid_n = skid;
    pending_n = pending;
    if (redirect) begin
      valid_n = 1'b0;
      ir_n = '0;
    end
    case (state)
      FETCH:
        if (imem_resp) begin
          if (redirect) pc_n = redirect_target;
          else if (forward_load) begin
            valid_n = 1'b1;
            ir_n = imem_rdata;
            ifpc_n = pc + 16'd2;
            pc_n = pc + 16'd2;
          end else begin
            skid_n = imem_rdata;
            pc_n = pc + 16'd2;
            state_n = SKID;
          end
        end else if (redirect) begin
          pending_n = redirect_target;
          state_n = DROP;
        end else if (forward_load) begin
          valid_n = 1'b0;
          ir_n = '0;
        end
      SKID:
        if (redirect) begin
          pc_n = redirect_target;
          state_n = FETCH;
        end else if (forward_load) begin
          valid_n = 1'b1;
          ir_n = skid;
          ifpc_n = pc;
          state_n = FETCH;
        end
      DROP: begin
        if (redirect) pending_n = redirect_target;
        if (imem_resp) begin
          pc_n = redirect ? redirect_target : pending;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end
  always_comb begin
    imem_read = !reset && state != SKID;
    imem_address = pc;
    fetch_busy = state != SKID && !imem_resp;
    op = if_id_ir[15:12];
    if_id_dest = if_id_ir[11:9];
    if_id_sr1 = if_id_ir[8:6];
    if_id_sr2 = (op == 4'b0111 || op == 4'b0011 || op == 4'b1011) ? if_id_ir[11:9] : if_id_ir[2:0];
  end
endmodule

// File: tb/tb_lc3b_fetch_stage.sv
// tb_lc3b_fetch_stage: directed self-checking bench for the LC-3b fetch stage.
module tb_lc3b_fetch_stage;
  logic clk = 0, reset = 1, forward_load = 1, redirect = 0;
  logic [15:0] redirect_target = 0;
  logic imem_read, imem_resp, if_id_valid, fetch_busy;
  logic [15:0] imem_address, imem_rdata, if_id_ir, if_id_pc;
  logic [2:0] if_id_dest, if_id_sr1, if_id_sr2;
  logic manual = 0, m_resp = 0;
  logic [15:0] m_rdata = 0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;
  // Fast memory answers in the same cycle with 0x1000+addr; manual mode is driven by the tests.
  assign imem_resp = manual ? m_resp : imem_read;
  assign imem_rdata = manual ? m_rdata : 16'h1000 + imem_address;

  lc3b_fetch_stage dut (
    .clk(clk), .reset(reset), .forward_load(forward_load), .redirect(redirect),
    .redirect_target(redirect_target), .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .if_id_valid(if_id_valid),
    .if_id_ir(if_id_ir), .if_id_pc(if_id_pc), .if_id_dest(if_id_dest),
    .if_id_sr1(if_id_sr1), .if_id_sr2(if_id_sr2), .fetch_busy(fetch_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    step();
    step();
    tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b want 0", if_id_valid); end
    tests++; if (if_id_ir !== 16'h0000) begin fails++; $display("FAIL rst_ir got %h want 0000", if_id_ir); end
    tests++; if (if_id_pc !== 16'h0000) begin fails++; $display("FAIL rst_pc got %h want 0000", if_id_pc); end
    tests++; if (imem_read !== 1'b0) begin fails++; $display("FAIL rst_read got %0b want 0", imem_read); end
    tests++; if (imem_address !== 16'h0000) begin fails++; $display("FAIL rst_addr got %h want 0000", imem_address); end
    reset = 0;
    #1;
    tests++; if (imem_read !== 1'b1) begin fails++; $display("FAIL post_rst_read got %0b want 1", imem_read); end
  endtask

  task automatic test_straight_line();
    for (int i = 0; i < 8; i++) begin
      step();
      tests++; if (if_id_pc !== 16'(2 * (i + 1))) begin fails++; $display("FAIL seq_pc[%0d] got %h want %h", i, if_id_pc, 16'(2 * (i + 1))); end
      tests++; if (if_id_ir !== 16'(16'h1000 + 2 * i)) begin fails++; $display("FAIL seq_ir[%0d] got %h want %h", i, if_id_ir, 16'(16'h1000 + 2 * i)); end
      tests++; if (if_id_valid !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d] got %0b want 1", i, if_id_valid); end
    end
    tests++; if (imem_address !== 16'h0010) begin fails++; $display("FAIL seq_addr got %h want 0010", imem_address); end
  endtask

  task automatic test_load_use_stall();
    forward_load = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++; if (if_id_ir !== 16'h100E || if_id_pc !== 16'h0010 || if_id_valid !== 1'b1) begin fails++; $display("FAIL stall_hold[%0d] got %h/%h/%0b want 100e/0010/1", i, if_id_ir, if_id_pc, if_id_valid); end
      tests++; if (imem_read !== 1'b0 || imem_address !== 16'h0012) begin fails++; $display("FAIL stall_req[%0d] got %0b/%h want 0/0012", i, imem_read, imem_address); end
    end
    forward_load = 1;
    step();
    tests++; if (if_id_ir !== 16'h1010 || if_id_pc !== 16'h0012 || if_id_valid !== 1'b1) begin fails++; $display("FAIL skid_out got %h/%h/%0b want 1010/0012/1", if_id_ir, if_id_pc, if_id_valid); end
    step();
    tests++; if (if_id_ir !== 16'h1012 || if_id_pc !== 16'h0014) begin fails++; $display("FAIL after_skid got %h/%h want 1012/0014", if_id_ir, if_id_pc); end
  endtask

  task automatic test_redirect_stall();
    forward_load = 0;
    step();
    redirect = 1;
    redirect_target = 16'h0300;
    step();
    redirect = 0;
    tests++; if (if_id_valid !== 1'b0 || if_id_ir !== 16'h0000) begin fails++; $display("FAIL redir_squash got %0b/%h want 0/0000", if_id_valid, if_id_ir); end
    tests++; if (imem_address !== 16'h0300 || imem_read !== 1'b1) begin fails++; $display("FAIL redir_addr got %h/%0b want 0300/1", imem_address, imem_read); end
    forward_load = 1;
    step();
    tests++; if (if_id_ir !== 16'h1300 || if_id_pc !== 16'h0302 || if_id_valid !== 1'b1) begin fails++; $display("FAIL redir_first got %h/%h/%0b want 1300/0302/1", if_id_ir, if_id_pc, if_id_valid); end
  endtask

  task automatic test_slow_redirect();
    manual = 1;
    m_resp = 0;
    redirect = 1;
    redirect_target = 16'h0400;
    #1;
    tests++; if (fetch_busy !== 1'b1) begin fails++; $display("FAIL slow_busy got %0b want 1", fetch_busy); end
    step();
    tests++; if (imem_address !== 16'h0302 || imem_read !== 1'b1 || if_id_valid !== 1'b0) begin fails++; $display("FAIL drop_hold got %h/%0b/%0b want 0302/1/0", imem_address, imem_read, if_id_valid); end
    redirect_target = 16'h0500;
    step();
    redirect = 0;
    m_resp = 1;
    m_rdata = 16'hDEAD;
    #1;
    tests++; if (fetch_busy !== 1'b0) begin fails++; $display("FAIL drop_resp_busy got %0b want 0", fetch_busy); end
    step();
    tests++; if (imem_address !== 16'h0500 || if_id_valid !== 1'b0 || if_id_ir !== 16'h0000) begin fails++; $display("FAIL drop_done got %h/%0b/%h want 0500/0/0000", imem_address, if_id_valid, if_id_ir); end
    m_rdata = 16'h2500;
    step();
    tests++; if (if_id_ir !== 16'h2500 || if_id_pc !== 16'h0502 || if_id_valid !== 1'b1) begin fails++; $display("FAIL drop_next got %h/%h/%0b want 2500/0502/1", if_id_ir, if_id_pc, if_id_valid); end
  endtask

  task automatic test_decode();
    m_rdata = 16'h7741;
    step();
    tests++; if (if_id_sr1 !== 3'd5 || if_id_sr2 !== 3'd3 || if_id_dest !== 3'd3) begin fails++; $display("FAIL dec_str got %0d/%0d/%0d want 5/3/3", if_id_sr1, if_id_sr2, if_id_dest); end
    m_rdata = 16'h1286;
    step();
    tests++; if (if_id_dest !== 3'd1 || if_id_sr1 !== 3'd2 || if_id_sr2 !== 3'd6) begin fails++; $display("FAIL dec_add got %0d/%0d/%0d want 1/2/6", if_id_dest, if_id_sr1, if_id_sr2); end
  endtask

  task automatic test_wrap_reset();
    redirect = 1;
    redirect_target = 16'hFFFE;
    step();
    redirect = 0;
    tests++; if (imem_address !== 16'hFFFE) begin fails++; $display("FAIL wrap_addr got %h want fffe", imem_address); end
    m_rdata = 16'h3333;
    step();
    tests++; if (if_id_pc !== 16'h0000 || imem_address !== 16'h0000 || if_id_ir !== 16'h3333) begin fails++; $display("FAIL wrap got %h/%h/%h want 0000/0000/3333", if_id_pc, imem_address, if_id_ir); end
    forward_load = 0;
    step();
    reset = 1;
    step();
    tests++; if (if_id_valid !== 1'b0 || if_id_ir !== 16'h0000 || if_id_pc !== 16'h0000) begin fails++; $display("FAIL midrst_ifid got %0b/%h/%h want 0/0000/0000", if_id_valid, if_id_ir, if_id_pc); end
    tests++; if (imem_address !== 16'h0000 || imem_read !== 1'b0) begin fails++; $display("FAIL midrst_req got %h/%0b want 0000/0", imem_address, imem_read); end
    reset = 0;
    forward_load = 1;
    m_rdata = 16'h4444;
    #1;
    tests++; if (imem_read !== 1'b1) begin fails++; $display("FAIL midrst_read got %0b want 1", imem_read); end
    step();
    tests++; if (if_id_ir !== 16'h4444 || if_id_pc !== 16'h0002 || if_id_valid !== 1'b1) begin fails++; $display("FAIL late_resp got %h/%h/%0b want 4444/0002/1", if_id_ir, if_id_pc, if_id_valid); end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_load_use_stall();
    test_redirect_stall();
    test_slow_redirect();
    test_decode();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lc3b_fetch_stage.md
# lc3b_fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined LC-3b core. It owns the PC and issues read requests to the instruction memory port. It presents the fetched instruction, the incremented PC, and the decoded sr1/sr2/dest fields to the decode stage and to hazard detection. It obeys hazard detection's `forward_load` stall and the MEM-stage branch redirect.

## Interface
- No parameters; widths fixed by `lc3b_types` (`lc3b_word` = 16 bits, `lc3b_reg` = 3 bits).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `forward_load`  in  1  from hazard detection; 1 = IF/ID may advance, 0 = hold PC and IF/ID.
- `redirect`  in  1  taken branch/jump resolved downstream; squash younger instructions.
- `redirect_target`  in  16  new PC when `redirect`=1.
- `imem_read`  out  1  instruction read request.
- `imem_address`  out  16  request address, always equal to the current PC.
- `imem_rdata`  in  16  instruction word; valid only while `imem_resp`=1.
- `imem_resp`  in  1  read complete; may arrive in the same cycle as the request.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_ir`  out  16  fetched instruction; 16'h0000 when not valid.
- `if_id_pc`  out  16  address of instruction + 2.
- `if_id_dest`  out  3  `ir[11:9]`.
- `if_id_sr1`  out  3  `ir[8:6]`.
- `if_id_sr2`  out  3  `ir[11:9]` for STR/STB/STI (opcodes 0111/0011/1011), else `ir[2:0]`.
- `fetch_busy`  out  1  1 while in FETCH or DROP with no `imem_resp` this cycle.

## Operation
- State is the PC, the IF/ID register {valid, ir, pc}, a skid register (16 bits), a pending target (16 bits), and an FSM with three states: FETCH, SKID and DROP.
- `imem_read` = 1 in FETCH and DROP, 0 in SKID, and 0 while `reset`=1. `imem_address` stays stable until `imem_resp`.
- Redirect has priority over `forward_load` in every state. On redirect, IF/ID valid is set to 0 and ir to 0, even if stalled.
- **FETCH, resp=1:**
  - With redirect: PC <= target and the data is discarded.
  - Else with forward_load=1: IF/ID <= {1, rdata, PC+2} and PC <= PC+2.
  - Else: skid <= rdata, PC <= PC+2, go to SKID, and IF/ID is held.
- **FETCH, resp=0:**
  - With redirect: pending <= target, go to DROP.
  - Else with forward_load=1: IF/ID valid <= 0 (bubble).
  - Else: hold.
- **SKID:**
  - With redirect: skid is discarded, PC <= target, go to FETCH.
  - Else with forward_load=1: IF/ID <= {1, skid, PC} (PC already incremented), go to FETCH.
  - Else: hold.
- **DROP:**
  - The in-flight request to the old PC is completed, not aborted.
  - A redirect overwrites pending.
  - On resp: data is discarded, PC <= pending (or the same-cycle `redirect_target`), go to FETCH.
  - IF/ID valid stays 0.
- PC arithmetic is 16-bit modulo: 16'hFFFE + 2 = 16'h0000. Bit 0 of `redirect_target` is passed through unchanged.

## Timing
- Reset values: PC 0, state FETCH, IF/ID {0, 16'h0000, 16'h0000}, skid 0, pending 0. `imem_read`=1 in the first cycle after reset deasserts.
- Reset asserted mid-request returns to the reset state. A late `imem_resp` in the cycle after reset is treated as the response to the new PC-0 request.
- With single-cycle memory (resp in the same cycle as read) and no stalls, throughput is 1 instruction/cycle. The instruction appears on the IF/ID outputs 1 cycle after its resp.
- A stall that begins while resp=1 costs no refetch: the skid supplies the instruction in the cycle after `forward_load` returns to 1.
- Decoded fields are combinational from the IF/ID register, so hazard detection sees them in the same cycle.

## Test plan
- **Straight-line fetch:** 1-cycle memory, memory returns 16'h1000+addr, no stall. Required: IF/ID pc = 2, 4, 6… on consecutive cycles, ir matches, `if_id_valid` stays 1.
- **Load-use stall:** `forward_load`=0 for 2 cycles while resp=1 at PC 0x0010.
  - IF/ID is held for both cycles.
  - The 0x0010 instruction enters IF/ID on the first cycle `forward_load`=1, with pc = 0x0012.
  - No duplicate or skipped instruction.
- **Redirect during stall:** SKID holding an instruction, then `redirect`=1 with target 0x0300 and `forward_load`=0.
  - Next cycle: `if_id_valid`=0 and `imem_address`=0x0300.
  - The skid instruction never appears.
- **Redirect with slow memory:** resp latency 3, redirect to 0x0400 in the 1st wait cycle, and again to 0x0500 in the 2nd.
  - The old response is dropped.
  - The next request is to 0x0500.
- **Decode fields:** STR R3,R5,#1 (0x7741) gives sr1=5, sr2=3. ADD R1,R2,R6 (0x1286) gives dest=1, sr1=2, sr2=6.
- **Wrap and reset:** fetch at 0xFFFE gives next PC 0x0000. Asserting `reset` mid-stall gives all outputs their reset values on the next edge.
